// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time. It holds the
// PC until decode accepts each word, and it turns a redirect or a timeout into a clean refetch.
module ifetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_value,
  input  logic        flush,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        inst_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic        drop_q;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        err_q;
  logic        timeout_hit;

  // cnt holds the number of WAIT cycles already spent, so the TIMEOUT-th WAIT cycle gives up
  assign timeout_hit = (cnt == (TIMEOUT - 8'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drop_q    <= 1'b0;
      cnt       <= 8'd0;
      addr_q    <= RESET_ADDR;
      inst_q    <= 32'h0;
      inst_pc_q <= RESET_ADDR;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_q <= pc_value;
          // A flush here means pc_value is stale; wait one cycle for the redirected PC
          if (!flush) begin
            if (pc_value[1:0] != 2'b00) begin
              state     <= S_HOLD;
              inst_q    <= 32'h0;
              err_q     <= 1'b1;
              inst_pc_q <= pc_value;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (imem_gnt) begin
            state  <= S_WAIT;
            cnt    <= 8'd0;
            drop_q <= flush;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 8'd1;
          if (imem_rvalid || timeout_hit) begin
            if (drop_q || flush) begin
              state  <= S_IDLE;
              drop_q <= 1'b0;
            end else begin
              state     <= S_HOLD;
              inst_q    <= imem_rvalid ? imem_rdata : 32'h0;
              err_q     <= !imem_rvalid;
              inst_pc_q <= addr_q;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush || inst_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = (state == S_REQ);
  assign imem_addr  = addr_q;
  assign inst_valid = (state == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = err_q;
  assign pc_stall   = !((state == S_HOLD) && inst_ready && !flush);

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_3000: value of inst_pc after reset.
REQ-002 Parameter TIMEOUT, default 8'd255: maximum WAIT cycles before a bus-error completion, range 1..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 pc_value  in  32  current fetch address from the PC stage.
REQ-006 flush  in  1  redirect pulse; asserted in the same cycle the PC is loaded with a jump or branch target.
REQ-007 pc_stall  out  1  when high, the PC shall hold its value; when low, the PC advances.
REQ-008 imem_req  out  1  instruction-memory request valid.
REQ-009 imem_addr  out  32  request word address.
REQ-010 imem_gnt  in  1  memory accepted the request (handshake completes when imem_req && imem_gnt).
REQ-011 imem_rvalid  in  1  read data valid.
REQ-012 imem_rdata  in  32  read data.
REQ-013 inst_valid  out  1  fetched instruction available to decode.
REQ-014 inst  out  32  fetched instruction word.
REQ-015 inst_pc  out  32  address of inst.
REQ-016 inst_err  out  1  qualifies inst_valid; the word is invalid (misaligned address or timeout).
REQ-017 inst_ready  in  1  decode accepts (transfer when inst_valid && inst_ready).

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD; 2-bit encoding.
REQ-019 IDLE: one cycle; latch pc_value into addr_q; if addr_q[1:0]!=0 -> HOLD with error, else -> REQ.
REQ-020 REQ: imem_req=1, imem_addr=addr_q held stable until grant; on imem_gnt -> WAIT with timeout counter cleared.
REQ-021 WAIT: counter increments each cycle; on imem_rvalid capture imem_rdata into inst, set inst_err=0 -> HOLD; if counter==TIMEOUT with no rvalid, set inst=32'h0 and inst_err=1 -> HOLD.
REQ-022 rvalid and timeout in the same cycle: rvalid wins and inst_err=0.
REQ-023 HOLD: inst_valid=1; inst, inst_pc and inst_err stable until transfer; on inst_ready -> IDLE.
REQ-024 pc_stall = !(state==HOLD && inst_ready && !flush), so the PC advances exactly once per accepted instruction.
REQ-025 Response latency: at least 1 cycle from grant; minimum instruction turnaround is 4 cycles (IDLE, REQ, WAIT, HOLD).
REQ-026 Misaligned address (addr_q[1:0]!=0): no memory request; HOLD with inst=32'h0, inst_err=1, inst_pc=addr_q.
REQ-027 flush in IDLE or HOLD: drop inst_valid next cycle; go to IDLE, which samples the redirected pc_value.
REQ-028 flush in REQ without grant: withdraw imem_req next cycle and go to IDLE.
REQ-029 flush in REQ with grant in the same cycle, or flush in WAIT: set drop_q and remain in or enter WAIT; the returning rvalid (or timeout) is discarded, drop_q clears, and the FSM goes to IDLE without asserting inst_valid.
REQ-030 flush during a drop_q wait: no additional effect.
REQ-031 imem_rvalid outside WAIT: ignored.
REQ-032 At most one outstanding memory request at any time.

Reset
REQ-033 rst high at posedge: state=IDLE, drop_q=0, counter=0.
REQ-034 Reset values: inst_valid=0, inst=32'h0, inst_pc=RESET_ADDR, inst_err=0, imem_req=0, imem_addr=RESET_ADDR, pc_stall=1.
REQ-035 rst mid-transaction abandons any outstanding request; a late imem_rvalid after reset is ignored per REQ-031.
REQ-036 rst has priority over flush and all handshakes.

Verification
REQ-037 Reset, pc_value=32'h3000, gnt same cycle, rvalid 1 cycle later with 32'h2402_0001, inst_ready=1 -> inst_valid for 1 cycle, inst_pc=32'h3000, pc_stall low exactly that cycle.
REQ-038 Grant delayed 3 cycles -> imem_req and imem_addr=32'h3000 held stable for 4 cycles, single WAIT entry.
REQ-039 inst_ready held low 5 cycles in HOLD -> inst and inst_pc stable, pc_stall=1 throughout, no new imem_req.
REQ-040 flush in WAIT with pc_value changing to 32'h3100, rvalid 2 cycles later -> no inst_valid for 32'h3000; next request addr=32'h3100.
REQ-041 TIMEOUT=4, grant but never rvalid -> inst_valid with inst_err=1, inst=0 after 4 WAIT cycles.
REQ-042 pc_value=32'h3002 -> no imem_req; inst_valid with inst_err=1, inst_pc=32'h3002.
